// File: rtl/eth_types_pkg.sv
// Shared Ethernet receive types and constants: RMII receiver states and the
// reflected CRC-32 parameters used for FCS generation and checking.
package eth_types_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DRAIN
    } rmii_states;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide next-state function of the reflected CRC-32 (LSB-first).
// Purely combinational; the CRC register belongs to the caller.
module crc32_d8
    import eth_types_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] crc_v;

    // Fold the byte in, then clock the LFSR eight times, one bit per step.
    always_comb begin
        crc_v = crc_in ^ {24'h000000, data_in};
        for (int i = 0; i < 8; i++) begin
            if (crc_v[0]) begin
                crc_v = (crc_v >> 1) ^ CRC32_POLY_REFL;
            end else begin
                crc_v = crc_v >> 1;
            end
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/rmii_rx.sv
// RMII receive front end: qualifies dibits against crs_dv, finds the SFD,
// assembles bytes, checks the CRC-32 FCS and reports frame status.
module rmii_rx
    import eth_types_pkg::*;
#(
    parameter int MIN_PREAMBLE_DIBITS = 8,
    parameter int MAX_FRAME_BYTES     = 1522
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] rxd,
    input  logic       crs_dv,
    input  logic       rx_er,
    output logic [7:0] received_byte,
    output logic       byte_valid,
    output logic       frame_active,
    output logic       frame_done,
    output logic       fcs_ok,
    output logic       rx_error
);

    localparam int PRE_W = $clog2(MIN_PREAMBLE_DIBITS + 1);
    localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);
    localparam logic [PRE_W-1:0] PRE_MIN = PRE_W'(MIN_PREAMBLE_DIBITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FRAME_BYTES);
    localparam logic [CNT_W-1:0] CNT_FCS = CNT_W'(4);

    logic [1:0]       rxd_q1, rxd_q2;
    logic             er_q1, er_q2;
    logic             dv_q1, dv_q2;
    logic             qual;

    rmii_states       state, state_next;
    logic [PRE_W-1:0] pre_cnt, pre_cnt_next;
    logic [1:0]       phase, phase_next;
    logic [5:0]       shift, shift_next;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_next;
    logic             err_flag, err_next;
    logic [31:0]      crc_q, crc_next, crc_upd;
    logic [7:0]       assembled;
    logic [7:0]       byte_next;
    logic             valid_next, active_next, done_next, fcs_ok_next, rx_error_next;

    // Two-stage input pipeline so the crs_dv sample after a dibit is known
    // before that dibit is acted upon.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_q1 <= 2'b00;
            rxd_q2 <= 2'b00;
            er_q1  <= 1'b0;
            er_q2  <= 1'b0;
            dv_q1  <= 1'b0;
            dv_q2  <= 1'b0;
        end else begin
            rxd_q1 <= rxd;
            rxd_q2 <= rxd_q1;
            er_q1  <= rx_er;
            er_q2  <= er_q1;
            dv_q1  <= crs_dv;
            dv_q2  <= dv_q1;
        end
    end

    // A dibit is data if crs_dv was high with it or on the following cycle;
    // a dibit that fails this means two consecutive low samples (end of carrier).
    assign qual      = dv_q2 | dv_q1;
    assign assembled = {rxd_q2, shift};

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data_in (assembled),
        .crc_out (crc_upd)
    );

    // State and datapath registers, including the registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            pre_cnt       <= '0;
            phase         <= 2'd0;
            shift         <= 6'd0;
            byte_cnt      <= '0;
            err_flag      <= 1'b0;
            crc_q         <= CRC32_INIT;
            received_byte <= 8'h00;
            byte_valid    <= 1'b0;
            frame_active  <= 1'b0;
            frame_done    <= 1'b0;
            fcs_ok        <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            state         <= state_next;
            pre_cnt       <= pre_cnt_next;
            phase         <= phase_next;
            shift         <= shift_next;
            byte_cnt      <= byte_cnt_next;
            err_flag      <= err_next;
            crc_q         <= crc_next;
            received_byte <= byte_next;
            byte_valid    <= valid_next;
            frame_active  <= active_next;
            frame_done    <= done_next;
            fcs_ok        <= fcs_ok_next;
            rx_error      <= rx_error_next;
        end
    end

    // Next-state and next-output logic for preamble hunt, byte assembly and drain.
    always_comb begin
        state_next    = state;
        pre_cnt_next  = pre_cnt;
        phase_next    = phase;
        shift_next    = shift;
        byte_cnt_next = byte_cnt;
        err_next      = err_flag;
        crc_next      = crc_q;
        byte_next     = received_byte;
        valid_next    = 1'b0;
        active_next   = frame_active;
        done_next     = 1'b0;
        fcs_ok_next   = 1'b0;
        rx_error_next = 1'b0;

        case (state)
            IDLE: begin
                if (qual) begin
                    if (rxd_q2 == 2'b01) begin
                        state_next   = PREAMBLE;
                        pre_cnt_next = PRE_W'(1);
                    end else if (rxd_q2 != 2'b00) begin
                        state_next = DRAIN;
                    end
                end
            end
            PREAMBLE: begin
                if (!qual) begin
                    state_next = IDLE;
                end else if (rxd_q2 == 2'b01) begin
                    if (pre_cnt < PRE_MIN) begin
                        pre_cnt_next = pre_cnt + PRE_W'(1);
                    end
                end else if ((rxd_q2 == 2'b11) && (pre_cnt >= PRE_MIN)) begin
                    byte_next     = SFD_BYTE;
                    valid_next    = 1'b1;
                    active_next   = 1'b1;
                    phase_next    = 2'd0;
                    byte_cnt_next = '0;
                    err_next      = 1'b0;
                    crc_next      = CRC32_INIT;
                    state_next    = DATA;
                end else begin
                    state_next = DRAIN;
                end
            end
            DATA: begin
                if (!qual) begin
                    done_next     = 1'b1;
                    active_next   = 1'b0;
                    rx_error_next = err_flag | (phase != 2'd0);
                    fcs_ok_next   = (crc_q == CRC32_RESIDUE) && !err_flag &&
                                    (phase == 2'd0) && (byte_cnt >= CNT_FCS);
                    err_next      = rx_error_next;
                    state_next    = IDLE;
                end else begin
                    err_next   = err_flag | er_q2;
                    shift_next = {rxd_q2, shift[5:2]};
                    phase_next = phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (byte_cnt == CNT_MAX) begin
                            done_next     = 1'b1;
                            active_next   = 1'b0;
                            rx_error_next = 1'b1;
                            state_next    = DRAIN;
                        end else begin
                            byte_next     = assembled;
                            valid_next    = 1'b1;
                            crc_next      = crc_upd;
                            byte_cnt_next = byte_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (!qual) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rmii_rx.sv
// Directed self-checking bench for rmii_rx.
module tb_rmii_rx;

    localparam int MIN_PRE   = 8;
    localparam int MAX_BYTES = 1522;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] rxd    = 2'b00;
    logic       crs_dv = 1'b0;
    logic       rx_er  = 1'b0;
    logic [7:0] received_byte;
    logic       byte_valid, frame_active, frame_done, fcs_ok, rx_error;

    rmii_rx #(.MIN_PREAMBLE_DIBITS(MIN_PRE), .MAX_FRAME_BYTES(MAX_BYTES)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .rxd           (rxd),
        .crs_dv        (crs_dv),
        .rx_er         (rx_er),
        .received_byte (received_byte),
        .byte_valid    (byte_valid),
        .frame_active  (frame_active),
        .frame_done    (frame_done),
        .fcs_ok        (fcs_ok),
        .rx_error      (rx_error)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mon_byte[$];
    int         mon_cyc[$];
    logic       mon_act[$];
    int         done_cyc[$];
    logic       done_fcs[$];
    logic       done_err[$];

    logic [3:0] tx[$];
    logic [7:0] exp_bytes[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every byte strobe and frame_done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (byte_valid === 1'b1) begin
            mon_byte.push_back(received_byte);
            mon_cyc.push_back(cyc);
            mon_act.push_back(frame_active);
        end
        if (frame_done === 1'b1) begin
            done_cyc.push_back(cyc);
            done_fcs.push_back(fcs_ok);
            done_err.push_back(rx_error);
        end
    end

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    function automatic int first_mismatch(input int b0);
        for (int i = 0; i < exp_bytes.size(); i++) begin
            if (b0 + i >= mon_byte.size()) return i;
            if (mon_byte[b0 + i] !== exp_bytes[i]) return i;
        end
        return -1;
    endfunction

    function automatic int bad_gaps(input int b0);
        int n;
        n = 0;
        for (int i = b0 + 1; i < mon_cyc.size(); i++) begin
            if (mon_cyc[i] - mon_cyc[i - 1] != 4) n++;
        end
        return n;
    endfunction

    function automatic int inactive_strobes(input int b0);
        int n;
        n = 0;
        for (int i = b0; i < mon_act.size(); i++) begin
            if (mon_act[i] !== 1'b1) n++;
        end
        return n;
    endfunction

    // Build dibit list {er, dv, rxd} plus the expected byte stream (SFD first).
    task automatic build_frame(input int npay, input int pre, input int flip,
                               input int er_byte, input int extra, input bit toggle);
        logic [7:0]  pay[$];
        logic [31:0] crc, fcs;
        logic [7:0]  b;
        logic [3:0]  e;
        tx.delete();
        exp_bytes.delete();
        for (int i = 0; i < pre; i++) tx.push_back(4'b0101);
        tx.push_back(4'b0111);
        exp_bytes.push_back(8'hD5);
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < npay; i++) begin
            b = 8'(i * 7 + 3);
            crc = crc_step(crc, b);
            pay.push_back(b);
        end
        fcs = ~crc;
        for (int k = 0; k < 4; k++) pay.push_back(fcs[8*k +: 8]);
        for (int i = 0; i < pay.size(); i++) begin
            b = pay[i];
            if (i == flip) b = b ^ 8'h01;
            exp_bytes.push_back(b);
            for (int k = 0; k < 4; k++) begin
                tx.push_back({(i == er_byte) && (k == 0), 1'b1, b[2*k +: 2]});
            end
        end
        for (int i = 0; i < extra; i++) tx.push_back(4'b0110);
        if (toggle) begin
            for (int k = 0; k < 8; k++) begin
                e = tx[tx.size() - 8 + k];
                e[2] = (k % 2 == 1);
                tx[tx.size() - 8 + k] = e;
            end
        end
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            {rx_er, crs_dv, rxd} = tx[i];
        end
    endtask

    task automatic go_idle(input int n);
        @(negedge clk);
        {rx_er, crs_dv, rxd} = 4'b0000;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({received_byte, byte_valid, frame_active, frame_done, fcs_ok, rx_error} !== 13'h0) begin
            bad++;
            $display("[TB] FAIL reset_hold: outputs=%h required 0",
                     {received_byte, byte_valid, frame_active, frame_done, fcs_ok, rx_error});
        end
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({received_byte, byte_valid, frame_active, frame_done, fcs_ok, rx_error} !== 13'h0) begin
            bad++;
            $display("[TB] FAIL reset_idle: outputs=%h required 0",
                     {received_byte, byte_valid, frame_active, frame_done, fcs_ok, rx_error});
        end
    endtask

    task automatic test_good_frame();
        int b0, d0, nb, nd, mm, lastb;
        logic fo, eo;
        build_frame(60, 31, -1, -1, 0, 1'b0);
        b0 = mon_byte.size();
        d0 = done_cyc.size();
        send_range(0, tx.size());
        go_idle(24);
        nb = mon_byte.size() - b0;
        nd = done_cyc.size() - d0;
        mm = first_mismatch(b0);
        fo = (nd > 0) ? done_fcs[d0] : 1'bx;
        eo = (nd > 0) ? done_err[d0] : 1'bx;
        lastb = (nb > 0) ? mon_cyc[mon_cyc.size() - 1] : 0;
        total++; if (nb !== 65) begin bad++; $display("[TB] FAIL good_count: got %0d required 65", nb); end
        total++; if (nb > 0 && mon_byte[b0] !== 8'hD5) begin bad++; $display("[TB] FAIL good_sfd: got %h required d5", mon_byte[b0]); end
        total++; if (mm !== -1) begin bad++; $display("[TB] FAIL good_bytes: first bad index %0d", mm); end
        total++; if (bad_gaps(b0) !== 0) begin bad++; $display("[TB] FAIL good_spacing: %0d gaps not 4 cycles", bad_gaps(b0)); end
        total++; if (inactive_strobes(b0) !== 0) begin bad++; $display("[TB] FAIL good_active: %0d strobes without frame_active", inactive_strobes(b0)); end
        total++; if (nd !== 1) begin bad++; $display("[TB] FAIL good_done_count: got %0d required 1", nd); end
        total++; if (fo !== 1'b1 || eo !== 1'b0) begin bad++; $display("[TB] FAIL good_status: fcs_ok=%b rx_error=%b required 1/0", fo, eo); end
        total++; if (nd > 0 && !(done_cyc[d0] > lastb)) begin bad++; $display("[TB] FAIL good_done_order: done cycle %0d last byte cycle %0d", done_cyc[d0], lastb); end
        total++; if (frame_active !== 1'b0) begin bad++; $display("[TB] FAIL good_active_end: got %b required 0", frame_active); end
    endtask

    task automatic test_bad_crc();
        int b0, d0, nb, nd, mm;
        logic fo, eo;
        build_frame(60, 31, 20, -1, 0, 1'b0);
        b0 = mon_byte.size();
        d0 = done_cyc.size();
        send_range(0, tx.size());
        go_idle(24);
        nb = mon_byte.size() - b0;
        nd = done_cyc.size() - d0;
        mm = first_mismatch(b0);
        fo = (nd > 0) ? done_fcs[d0] : 1'bx;
        eo = (nd > 0) ? done_err[d0] : 1'bx;
        total++; if (nb !== 65 || mm !== -1) begin bad++; $display("[TB] FAIL badcrc_bytes: count %0d first bad %0d required 65/-1", nb, mm); end
        total++; if (nd !== 1 || fo !== 1'b0 || eo !== 1'b0) begin bad++; $display("[TB] FAIL badcrc_status: done=%0d fcs_ok=%b rx_error=%b required 1/0/0", nd, fo, eo); end
    endtask

    task automatic test_crs_toggle();
        int b0, d0, nb, nd, mm, lastb;
        logic fo, eo;
        build_frame(60, 31, -1, -1, 0, 1'b1);
        b0 = mon_byte.size();
        d0 = done_cyc.size();
        send_range(0, tx.size());
        go_idle(24);
        nb = mon_byte.size() - b0;
        nd = done_cyc.size() - d0;
        mm = first_mismatch(b0);
        fo = (nd > 0) ? done_fcs[d0] : 1'bx;
        eo = (nd > 0) ? done_err[d0] : 1'bx;
        lastb = (nb > 0) ? mon_cyc[mon_cyc.size() - 1] : 0;
        total++; if (nb !== 65 || mm !== -1) begin bad++; $display("[TB] FAIL toggle_bytes: count %0d first bad %0d required 65/-1", nb, mm); end
        total++; if (nd !== 1) begin bad++; $display("[TB] FAIL toggle_done_count: got %0d required 1", nd); end
        total++; if (fo !== 1'b1 || eo !== 1'b0) begin bad++; $display("[TB] FAIL toggle_status: fcs_ok=%b rx_error=%b required 1/0", fo, eo); end
        total++; if (nd > 0 && !(done_cyc[d0] > lastb)) begin bad++; $display("[TB] FAIL toggle_done_order: done cycle %0d last byte cycle %0d", done_cyc[d0], lastb); end
    endtask

    task automatic test_rx_er();
        int b0, d0, nb, nd;
        logic fo, eo;
        build_frame(60, 31, -1, 30, 0, 1'b0);
        b0 = mon_byte.size();
        d0 = done_cyc.size();
        send_range(0, tx.size());
        go_idle(24);
        nb = mon_byte.size() - b0;
        nd = done_cyc.size() - d0;
        fo = (nd > 0) ? done_fcs[d0] : 1'bx;
        eo = (nd > 0) ? done_err[d0] : 1'bx;
        total++; if (nb !== 65) begin bad++; $display("[TB] FAIL rxer_count: got %0d required 65", nb); end
        total++; if (nd !== 1 || fo !== 1'b0 || eo !== 1'b1) begin bad++; $display("[TB] FAIL rxer_status: done=%0d fcs_ok=%b rx_error=%b required 1/0/1", nd, fo, eo); end
    endtask

    task automatic test_extra_dibit();
        int b0, d0, nb, nd, mm;
        logic fo, eo;
        build_frame(60, 31, -1, -1, 1, 1'b0);
        b0 = mon_byte.size();
        d0 = done_cyc.size();
        send_range(0, tx.size());
        go_idle(24);
        nb = mon_byte.size() - b0;
        nd = done_cyc.size() - d0;
        mm = first_mismatch(b0);
        fo = (nd > 0) ? done_fcs[d0] : 1'bx;
        eo = (nd > 0) ? done_err[d0] : 1'bx;
        total++; if (nb !== 65 || mm !== -1) begin bad++; $display("[TB] FAIL extra_bytes: count %0d first bad %0d required 65/-1", nb, mm); end
        total++; if (nd !== 1 || fo !== 1'b0 || eo !== 1'b1) begin bad++; $display("[TB] FAIL extra_status: done=%0d fcs_ok=%b rx_error=%b required 1/0/1", nd, fo, eo); end
    endtask

    task automatic test_preamble_boundary();
        int b0, d0, nb, nd;
        logic fo;
        build_frame(60, MIN_PRE - 1, -1, -1, 0, 1'b0);
        b0 = mon_byte.size();
        d0 = done_cyc.size();
        send_range(0, tx.size());
        go_idle(24);
        nb = mon_byte.size() - b0;
        nd = done_cyc.size() - d0;
        total++; if (nb !== 0 || nd !== 0) begin bad++; $display("[TB] FAIL short_preamble: strobes=%0d done=%0d required 0/0", nb, nd); end
        build_frame(60, MIN_PRE, -1, -1, 0, 1'b0);
        b0 = mon_byte.size();
        d0 = done_cyc.size();
        send_range(0, tx.size());
        go_idle(24);
        nb = mon_byte.size() - b0;
        nd = done_cyc.size() - d0;
        fo = (nd > 0) ? done_fcs[d0] : 1'bx;
        total++; if (nb !== 65 || first_mismatch(b0) !== -1) begin bad++; $display("[TB] FAIL min_preamble_bytes: count %0d required 65", nb); end
        total++; if (nd !== 1 || fo !== 1'b1) begin bad++; $display("[TB] FAIL min_preamble_status: done=%0d fcs_ok=%b required 1/1", nd, fo); end
    endtask

    task automatic test_false_carrier();
        int b0, d0, nb, nd;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            {rx_er, crs_dv, rxd} = 4'b0110;
        end
        b0 = mon_byte.size();
        d0 = done_cyc.size();
        go_idle(24);
        nb = mon_byte.size() - b0;
        nd = done_cyc.size() - d0;
        total++; if (nb !== 0 || nd !== 0) begin bad++; $display("[TB] FAIL false_carrier: strobes=%0d done=%0d required 0/0", nb, nd); end
        test_good_frame();
    endtask

    task automatic test_reset_midframe();
        int b0, d0, nb, nd, k;
        build_frame(60, 31, -1, -1, 0, 1'b0);
        k = 32 + 10 * 4 + 2;
        send_range(0, k);
        #3;
        total++; if (frame_active !== 1'b1) begin bad++; $display("[TB] FAIL midreset_pre_active: got %b required 1", frame_active); end
        resetn = 1'b0;
        #1;
        total++;
        if ({received_byte, byte_valid, frame_active, frame_done, fcs_ok, rx_error} !== 13'h0) begin
            bad++;
            $display("[TB] FAIL midreset_clear: outputs=%h required 0",
                     {received_byte, byte_valid, frame_active, frame_done, fcs_ok, rx_error});
        end
        @(posedge clk);
        #2;
        resetn = 1'b1;
        b0 = mon_byte.size();
        d0 = done_cyc.size();
        send_range(k, tx.size());
        go_idle(24);
        nb = mon_byte.size() - b0;
        nd = done_cyc.size() - d0;
        total++; if (nb !== 0 || nd !== 0) begin bad++; $display("[TB] FAIL midreset_quiet: strobes=%0d done=%0d required 0/0", nb, nd); end
        test_good_frame();
    endtask

    task automatic test_max_length();
        int b0, d0, nb, nd, mm;
        logic fo, eo;
        build_frame(MAX_BYTES - 4, 31, -1, -1, 0, 1'b0);
        b0 = mon_byte.size();
        d0 = done_cyc.size();
        send_range(0, tx.size());
        go_idle(24);
        nb = mon_byte.size() - b0;
        nd = done_cyc.size() - d0;
        mm = first_mismatch(b0);
        fo = (nd > 0) ? done_fcs[d0] : 1'bx;
        eo = (nd > 0) ? done_err[d0] : 1'bx;
        total++; if (nb !== MAX_BYTES + 1 || mm !== -1) begin bad++; $display("[TB] FAIL maxlen_bytes: count %0d first bad %0d required %0d/-1", nb, mm, MAX_BYTES + 1); end
        total++; if (nd !== 1 || fo !== 1'b1 || eo !== 1'b0) begin bad++; $display("[TB] FAIL maxlen_status: done=%0d fcs_ok=%b rx_error=%b required 1/1/0", nd, fo, eo); end
    endtask

    task automatic test_oversize();
        int b0, d0, nb, nd, mm;
        logic fo, eo;
        build_frame(MAX_BYTES - 3, 31, -1, -1, 0, 1'b0);
        while (exp_bytes.size() > MAX_BYTES + 1) void'(exp_bytes.pop_back());
        b0 = mon_byte.size();
        d0 = done_cyc.size();
        send_range(0, tx.size());
        go_idle(24);
        nb = mon_byte.size() - b0;
        nd = done_cyc.size() - d0;
        mm = first_mismatch(b0);
        fo = (nd > 0) ? done_fcs[d0] : 1'bx;
        eo = (nd > 0) ? done_err[d0] : 1'bx;
        total++; if (nb !== MAX_BYTES + 1 || mm !== -1) begin bad++; $display("[TB] FAIL oversize_bytes: count %0d first bad %0d required %0d/-1", nb, mm, MAX_BYTES + 1); end
        total++; if (nd !== 1 || fo !== 1'b0 || eo !== 1'b1) begin bad++; $display("[TB] FAIL oversize_status: done=%0d fcs_ok=%b rx_error=%b required 1/0/1", nd, fo, eo); end
        total++; if (frame_active !== 1'b0) begin bad++; $display("[TB] FAIL oversize_active_end: got %b required 0", frame_active); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_crs_toggle();
        test_rx_er();
        test_extra_dibit();
        test_preamble_boundary();
        test_false_carrier();
        test_reset_midframe();
        test_max_length();
        test_oversize();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
